text_glyph_shifter: RTL and testbench

//  Text-mode stage downstream of the 8KB font BRAM.
//  - Accepts character cells: code, attribute, font bank, glyph row.
//  - Drives the font read address; captures the returned glyph byte.
//  - Serializes the byte MSB-first into 4-bit pixel colours, one per pix_en.
//  - Double-buffers fetch vs. shift so back-to-back cells give gapless pixels.

---
 rtl/text_glyph_shifter.sv | 176 +++++++++++++++++
 tb/tb_text_glyph_shifter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/text_glyph_shifter.sv
// Text-mode glyph stage: fetches a font byte per character cell and serializes it MSB-first into 4-bit colours.
// Optional build macro TEXT_CURSOR_EN adds cursor_in, which inverts the fetched glyph byte of that cell.
module text_glyph_shifter #(
  parameter int ADDR_W = 13,
  parameter int ROW_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              char_valid,
  output logic              char_ready,
  input  logic [7:0]        char_code,
  input  logic [7:0]        char_attr,
  input  logic              font_bank,
  input  logic [ROW_W-1:0]  glyph_row,
`ifdef TEXT_CURSOR_EN
  input  logic              cursor_in,
`endif
  output logic [ADDR_W-1:0] font_rd_addr,
  input  logic [7:0]        font_data,
  input  logic              pix_en,
  output logic              pix_valid,
  output logic [3:0]        pix_color,
  output logic              underrun
);

  logic              f1_q, f1_d;
  logic              f2_q, f2_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        lat_attr_q, lat_attr_d;
  logic [7:0]        hold_bits_q, hold_bits_d;
  logic [7:0]        hold_attr_q, hold_attr_d;
  logic              hold_valid_q, hold_valid_d;
  logic [7:0]        shift_bits_q, shift_bits_d;
  logic [7:0]        shift_attr_q, shift_attr_d;
  logic [2:0]        shift_cnt_q, shift_cnt_d;
  logic              shift_valid_q, shift_valid_d;
  logic              underrun_q, underrun_d;
  logic              accept_s;
  logic              last_s;
  logic              load_s;
  logic [7:0]        glyph_s;

  assign char_ready   = ~(f1_q | f2_q | hold_valid_q);
  assign font_rd_addr = addr_q;
  assign pix_valid    = shift_valid_q;
  assign underrun     = underrun_q;

`ifdef TEXT_CURSOR_EN
  logic lat_cursor_q, lat_cursor_d;

  // Cursor flag travels with the cell; a set flag inverts the glyph so fg and bg swap.
  always_comb begin
    lat_cursor_d = lat_cursor_q;
    if (accept_s) begin
      lat_cursor_d = cursor_in;
    end else begin
      lat_cursor_d = lat_cursor_q;
    end
    if (lat_cursor_q) begin
      glyph_s = font_data ^ 8'hFF;
    end else begin
      glyph_s = font_data;
    end
  end

  // Cursor latch register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_cursor_q <= 1'b0;
    end else begin
      lat_cursor_q <= lat_cursor_d;
    end
  end
`else
  assign glyph_s = font_data;
`endif

  // Fetch pipeline: accept drives the address, f1/f2 track the one-clock BRAM latency.
  always_comb begin
    accept_s   = char_valid & char_ready;
    f1_d       = accept_s;
    f2_d       = f1_q;
    addr_d     = addr_q;
    lat_attr_d = lat_attr_q;
    if (accept_s) begin
      addr_d     = ADDR_W'({font_bank, char_code, glyph_row});
      lat_attr_d = char_attr;
    end else begin
      addr_d     = addr_q;
      lat_attr_d = lat_attr_q;
    end
  end

  // Hold buffer: captured when f2 is set, emptied when the shifter takes it.
  always_comb begin
    last_s      = (shift_cnt_q == 3'd7);
    load_s      = hold_valid_q & (~shift_valid_q | (pix_en & last_s));
    hold_bits_d = hold_bits_q;
    hold_attr_d = hold_attr_q;
    hold_valid_d = hold_valid_q;
    if (f2_q) begin
      hold_bits_d  = glyph_s;
      hold_attr_d  = lat_attr_q;
      hold_valid_d = 1'b1;
    end else if (load_s) begin
      hold_valid_d = 1'b0;
    end else begin
      hold_valid_d = hold_valid_q;
    end
  end

  // Pixel shifter: a reload on the eighth pixel keeps back-to-back cells gapless.
  always_comb begin
    shift_bits_d  = shift_bits_q;
    shift_attr_d  = shift_attr_q;
    shift_cnt_d   = shift_cnt_q;
    shift_valid_d = shift_valid_q;
    if (load_s) begin
      shift_bits_d  = hold_bits_q;
      shift_attr_d  = hold_attr_q;
      shift_cnt_d   = 3'd0;
      shift_valid_d = 1'b1;
    end else if (pix_en & shift_valid_q) begin
      shift_bits_d  = {shift_bits_q[6:0], 1'b0};
      shift_cnt_d   = shift_cnt_q + 3'd1;
      shift_valid_d = ~last_s;
    end else begin
      shift_valid_d = shift_valid_q;
    end
  end

  // Colour output and underrun detection.
  always_comb begin
    underrun_d = pix_en & ~shift_valid_q;
    pix_color  = 4'h0;
    if (!shift_valid_q) begin
      pix_color = 4'h0;
    end else if (shift_bits_q[7]) begin
      pix_color = shift_attr_q[3:0];
    end else begin
      pix_color = shift_attr_q[7:4];
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f1_q          <= 1'b0;
      f2_q          <= 1'b0;
      addr_q        <= '0;
      lat_attr_q    <= 8'h00;
      hold_bits_q   <= 8'h00;
      hold_attr_q   <= 8'h00;
      hold_valid_q  <= 1'b0;
      shift_bits_q  <= 8'h00;
      shift_attr_q  <= 8'h00;
      shift_cnt_q   <= 3'd0;
      shift_valid_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      f1_q          <= f1_d;
      f2_q          <= f2_d;
      addr_q        <= addr_d;
      lat_attr_q    <= lat_attr_d;
      hold_bits_q   <= hold_bits_d;
      hold_attr_q   <= hold_attr_d;
      hold_valid_q  <= hold_valid_d;
      shift_bits_q  <= shift_bits_d;
      shift_attr_q  <= shift_attr_d;
      shift_cnt_q   <= shift_cnt_d;
      shift_valid_q <= shift_valid_d;
      underrun_q    <= underrun_d;
    end
  end

endmodule

// File: tb/tb_text_glyph_shifter.sv
// Bench for text_glyph_shifter: directed vector table, corner sequences, and a random run against a cell-queue model.
module tb_text_glyph_shifter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [7:0]  char_code = 8'h00;
  logic [7:0]  char_attr = 8'h00;
  logic        font_bank = 1'b0;
  logic [3:0]  glyph_row = 4'h0;
  logic        cursor_in = 1'b0;
  logic [12:0] font_rd_addr;
  logic [7:0]  font_data = 8'h00;
  logic        pix_en = 1'b0;
  logic        pix_valid;
  logic [3:0]  pix_color;
  logic        underrun;

  text_glyph_shifter #(.ADDR_W(13), .ROW_W(4)) dut (
    .clk(clk), .reset(reset), .char_valid(char_valid), .char_ready(char_ready),
    .char_code(char_code), .char_attr(char_attr), .font_bank(font_bank), .glyph_row(glyph_row),
`ifdef TEXT_CURSOR_EN
    .cursor_in(cursor_in),
`endif
    .font_rd_addr(font_rd_addr), .font_data(font_data), .pix_en(pix_en),
    .pix_valid(pix_valid), .pix_color(pix_color), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Font BRAM model with one-clock registered read.
  logic [7:0] font_mem [0:8191];
  always @(posedge clk) font_data <= font_mem[font_rd_addr];

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [7:0]  code;
    logic [7:0]  attr;
    logic        bank;
    logic [3:0]  row;
    logic [7:0]  glyph;
    logic [12:0] exp_addr;
    logic [31:0] exp_pix;
  } vec_t;

  vec_t vecs [4];

  task automatic issue(input logic [7:0] code, input logic [7:0] attr, input logic bank,
                       input logic [3:0] row, input logic cur);
    @(negedge clk);
    char_code = code; char_attr = attr; font_bank = bank; glyph_row = row;
    cursor_in = cur; char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; char_valid = 1'b0; pix_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One cell: accept, 3-clock latency, 8 pixels, then empty.
  task automatic run_vec(input vec_t v, input logic cur);
    font_mem[v.exp_addr] = v.glyph;
    pix_en = 1'b0;
    issue(v.code, v.attr, v.bank, v.row, cur);
    check("vec_addr", font_rd_addr, v.exp_addr);
    @(negedge clk);
    @(negedge clk);
    check("vec_not_yet_valid", pix_valid, 1'b0);
    @(negedge clk);
    check("vec_valid_at_e3", pix_valid, 1'b1);
    pix_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("vec_pix", pix_color, v.exp_pix[31-4*i -: 4]);
      @(negedge clk);
    end
    pix_en = 1'b0;
    check("vec_drained", pix_valid, 1'b0);
    check("vec_no_underrun", underrun, 1'b0);
  endtask

  // Reference model: a pending cell becomes loadable 3 edges after accept; current cell yields 8 pixels.
  int          cyc;
  logic        m_pend_valid, m_cur_valid, m_underrun;
  int          m_pend_t, m_idx;
  logic [7:0]  m_pend_glyph, m_pend_attr, m_cur_glyph, m_cur_attr;
  logic [12:0] m_addr;

  task automatic model_reset();
    cyc = 0; m_pend_valid = 1'b0; m_cur_valid = 1'b0; m_underrun = 1'b0;
    m_pend_t = 0; m_idx = 0; m_addr = 13'h0000;
    m_pend_glyph = 8'h00; m_pend_attr = 8'h00; m_cur_glyph = 8'h00; m_cur_attr = 8'h00;
  endtask

  function automatic logic [3:0] m_color();
    if (!m_cur_valid) return 4'h0;
    return m_cur_glyph[7-m_idx] ? m_cur_attr[3:0] : m_cur_attr[7:4];
  endfunction

  task automatic model_step(input logic acc, input logic pe, input logic [12:0] a,
                            input logic [7:0] g, input logic [7:0] at);
    m_underrun = pe & !m_cur_valid;
    if (m_cur_valid && pe) begin
      m_idx++;
      if (m_idx == 8) m_cur_valid = 1'b0;
    end
    if (!m_cur_valid && m_pend_valid && (cyc - m_pend_t) >= 3) begin
      m_cur_valid = 1'b1; m_idx = 0;
      m_cur_glyph = m_pend_glyph; m_cur_attr = m_pend_attr;
      m_pend_valid = 1'b0;
    end
    if (acc) begin
      m_pend_valid = 1'b1; m_pend_t = cyc;
      m_pend_glyph = g; m_pend_attr = at; m_addr = a;
    end
    cyc++;
  endtask

  initial begin
    #3000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [12:0] a;
    logic [7:0]  g;
    logic        acc;
    vec_t        cv;

    for (int i = 0; i < 8192; i++) font_mem[i] = 8'($urandom);

    vecs[0] = '{8'h41, 8'h1F, 1'b0, 4'h3, 8'h3C, 13'h0413, 32'h11FFFF11};
    vecs[1] = '{8'hA5, 8'h3C, 1'b1, 4'hC, 8'hA5, 13'h1A5C, 32'hC3C33C3C};
    vecs[2] = '{8'hFF, 8'h72, 1'b0, 4'hF, 8'h0F, 13'h0FFF, 32'h77772222};
    vecs[3] = '{8'h00, 8'hE4, 1'b1, 4'h0, 8'h5A, 13'h1000, 32'hE4E44E4E};

    reset = 1'b1;
    @(negedge clk);
    check("reset_ready", char_ready, 1'b1);
    check("reset_pix_valid", pix_valid, 1'b0);
    check("reset_addr", font_rd_addr, 13'h0000);
    check("reset_color", pix_color, 4'h0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) run_vec(vecs[i], 1'b0);

    // Reset while a fetch is in flight.
    font_mem[13'h0555] = 8'hFF;
    issue(8'h55, 8'h1F, 1'b0, 4'h5, 1'b0);
    check("midfetch_busy", char_ready, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("midfetch_ready", char_ready, 1'b1);
    check("midfetch_pix_valid", pix_valid, 1'b0);
    check("midfetch_addr", font_rd_addr, 13'h0000);
    check("midfetch_underrun", underrun, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    check("midfetch_discarded", pix_valid, 1'b0);
    check("midfetch_still_ready", char_ready, 1'b1);

    // Two back-to-back cells stream 16 pixels without a gap.
    font_mem[13'h0FF0] = 8'hFF;
    font_mem[13'h0000] = 8'h00;
    issue(8'hFF, 8'h02, 1'b0, 4'h0, 1'b0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    char_code = 8'h00; char_attr = 8'h50; font_bank = 1'b0; glyph_row = 4'h0;
    char_valid = 1'b1; pix_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("b2b_valid", pix_valid, 1'b1);
      check("b2b_color", pix_color, (i < 8) ? 4'h2 : 4'h5);
      @(negedge clk);
      char_valid = 1'b0;
    end
    pix_en = 1'b0;
    check("b2b_drained", pix_valid, 1'b0);

    // Stalled shifting: colour holds while pix_en is low.
    font_mem[13'h0801] = 8'h80;
    issue(8'h80, 8'h1F, 1'b0, 4'h1, 1'b0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("stall_first", pix_color, 4'hF);
    @(negedge clk);
    check("stall_hold", pix_color, 4'hF);
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    check("stall_advance", pix_color, 4'h1);
    @(negedge clk);
    check("stall_hold2", pix_color, 4'h1);
    pix_en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check("stall_tail_valid", pix_valid, (k < 6) ? 1'b1 : 1'b0);
    end
    pix_en = 1'b0;
    @(negedge clk);

    // Underrun on an empty shifter.
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    check("underrun_pulse", underrun, 1'b1);
    check("underrun_color", pix_color, 4'h0);
    check("underrun_ready", char_ready, 1'b1);
    @(negedge clk);
    check("underrun_cleared", underrun, 1'b0);

`ifdef TEXT_CURSOR_EN
    cv = '{8'h41, 8'h1F, 1'b0, 4'h3, 8'h3C, 13'h0413, 32'hFF1111FF};
    run_vec(cv, 1'b1);
`endif

    // Random traffic against the reference model.
    do_reset();
    model_reset();
    for (int n = 0; n < 4000; n++) begin
      check("rnd_ready", char_ready, !m_pend_valid);
      check("rnd_pix_valid", pix_valid, m_cur_valid);
      check("rnd_color", pix_color, m_color());
      check("rnd_underrun", underrun, m_underrun);
      check("rnd_addr", font_rd_addr, m_addr);
      char_valid = ($urandom_range(0, 2) != 0);
      char_code  = 8'($urandom);
      char_attr  = 8'($urandom);
      font_bank  = 1'($urandom);
      glyph_row  = 4'($urandom);
`ifdef TEXT_CURSOR_EN
      cursor_in  = 1'($urandom);
`else
      cursor_in  = 1'b0;
`endif
      pix_en     = ($urandom_range(0, 3) != 0);
      a   = {font_bank, char_code, glyph_row};
      g   = font_mem[a] ^ (cursor_in ? 8'hFF : 8'h00);
      acc = char_valid & !m_pend_valid;
      model_step(acc, pix_en, a, g, char_attr);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
